// File: rtl/il_pkg.sv
// Shared definitions for the instruction-list fetch front end:
// default widths, the HALT opcode and the fetch FSM state encoding.
package il_pkg;

   localparam int PC_W    = 8;
   localparam int INST_W  = 16;
   localparam int OPC_W   = 5;
   localparam int FIELD_W = INST_W - OPC_W;

   localparam logic [OPC_W-1:0] HALT_OPC = 5'h1F;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_FETCH  = 3'd1,
      ST_DECODE = 3'd2,
      ST_ISSUE  = 3'd3,
      ST_HALT   = 3'd4
   } il_state_e;

endpackage : il_pkg

// File: rtl/il_pc_counter.sv
// Program counter: clears to 0, loads a redirect target, or increments
// with natural wrap from all-ones back to zero. Load wins over increment.
module il_pc_counter #(
   parameter int PC_W = 8
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            load_i,
   input  logic [PC_W-1:0] load_val_i,
   input  logic            inc_i,
   output logic [PC_W-1:0] pc_o
);

   logic [PC_W-1:0] pc_q;
   logic [PC_W-1:0] pc_d;

   // Next-pc selection: redirect, sequential advance, or hold.
   always_comb begin
      pc_d = pc_q;
      if (load_i) begin
         pc_d = load_val_i;
      end else if (inc_i) begin
         pc_d = pc_q + {{(PC_W-1){1'b0}}, 1'b1};
      end
   end

   // Program counter register.
   always_ff @(posedge clk) begin
      if (reset) begin
         pc_q <= '0;
      end else begin
         pc_q <= pc_d;
      end
   end

   assign pc_o = pc_q;

endmodule : il_pc_counter

// File: rtl/il_fetch_ctrl.sv
// Fetch sequencer: walks IDLE -> FETCH -> DECODE -> ISSUE, reads the
// program ROM one cycle ahead of capture, holds the issued word while
// decode stalls, honours branch redirects and parks in HALT.
module il_fetch_ctrl
   import il_pkg::*;
#(
   parameter int                PC_W     = il_pkg::PC_W,
   parameter int                INST_W   = il_pkg::INST_W,
   parameter int                OPC_W    = il_pkg::OPC_W,
   parameter logic [OPC_W-1:0]  HALT_OPC = il_pkg::HALT_OPC
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    run,
   input  logic                    stall,
   input  logic                    branch_en,
   input  logic [PC_W-1:0]         branch_addr,
   output logic                    rom_rd,
   output logic [PC_W-1:0]         rom_addr,
   input  logic [INST_W-1:0]       rom_data,
   output logic                    inst_valid,
   output logic [OPC_W-1:0]        inst_opcode,
   output logic [INST_W-OPC_W-1:0] inst_field,
   output logic [PC_W-1:0]         inst_pc,
   output logic                    halted,
   output logic [2:0]              state_dbg
);

   il_state_e          state_q, state_d;
   logic [INST_W-1:0]  ir_q, ir_d;
   logic [PC_W-1:0]    inst_pc_q, inst_pc_d;
   logic [PC_W-1:0]    pc;
   logic               pc_load;
   logic               pc_inc;

   il_pc_counter #(
      .PC_W (PC_W)
   ) u_pc (
      .clk        (clk),
      .reset      (reset),
      .load_i     (pc_load),
      .load_val_i (branch_addr),
      .inc_i      (pc_inc),
      .pc_o       (pc)
   );

   // Next state, IR capture and pc control. A redirect in any active
   // state drops the in-flight word and restarts fetching at the target.
   always_comb begin
      state_d   = state_q;
      ir_d      = ir_q;
      inst_pc_d = inst_pc_q;
      pc_load   = 1'b0;
      pc_inc    = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (run) begin
               state_d = ST_FETCH;
            end
         end
         ST_FETCH: begin
            if (branch_en) begin
               pc_load = 1'b1;
               state_d = ST_FETCH;
            end else begin
               state_d = ST_DECODE;
            end
         end
         ST_DECODE: begin
            if (branch_en) begin
               pc_load = 1'b1;
               state_d = ST_FETCH;
            end else begin
               ir_d      = rom_data;
               inst_pc_d = pc;
               pc_inc    = 1'b1;
               if (rom_data[INST_W-1 -: OPC_W] == HALT_OPC) begin
                  state_d = ST_HALT;
               end else begin
                  state_d = ST_ISSUE;
               end
            end
         end
         ST_ISSUE: begin
            if (branch_en) begin
               pc_load = 1'b1;
               state_d = ST_FETCH;
            end else if (!stall) begin
               state_d = run ? ST_FETCH : ST_IDLE;
            end
         end
         ST_HALT: begin
            state_d = ST_HALT;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State, instruction register and issued-address registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= ST_IDLE;
         ir_q      <= '0;
         inst_pc_q <= '0;
      end else begin
         state_q   <= state_d;
         ir_q      <= ir_d;
         inst_pc_q <= inst_pc_d;
      end
   end

   assign rom_rd      = (state_q == ST_FETCH);
   assign rom_addr    = pc;
   assign inst_valid  = (state_q == ST_ISSUE);
   assign halted      = (state_q == ST_HALT);
   assign state_dbg   = state_q;
   assign inst_opcode = ir_q[INST_W-1 -: OPC_W];
   assign inst_field  = ir_q[INST_W-OPC_W-1:0];
   assign inst_pc     = inst_pc_q;

endmodule : il_fetch_ctrl

// File: tb/tb_il_fetch_ctrl.sv
// Bench for il_fetch_ctrl: synchronous ROM model plus a scoreboard of
// expected issued instructions, popped on every accepted issue.
module tb_il_fetch_ctrl;

   logic        clk;
   logic        reset;
   logic        run;
   logic        stall;
   logic        branch_en;
   logic [7:0]  branch_addr;
   logic        rom_rd;
   logic [7:0]  rom_addr;
   logic [15:0] rom_data;
   logic        inst_valid;
   logic [4:0]  inst_opcode;
   logic [10:0] inst_field;
   logic [7:0]  inst_pc;
   logic        halted;
   logic [2:0]  state_dbg;

   typedef struct packed {
      logic [7:0]  pc;
      logic [15:0] word;
   } sb_entry_t;

   sb_entry_t   exp_q[$];
   sb_entry_t   mon_e;
   logic [15:0] rom [256];
   int          n_vec = 0;
   int          n_err = 0;
   int          cyc;

   il_fetch_ctrl dut (
      .clk         (clk),
      .reset       (reset),
      .run         (run),
      .stall       (stall),
      .branch_en   (branch_en),
      .branch_addr (branch_addr),
      .rom_rd      (rom_rd),
      .rom_addr    (rom_addr),
      .rom_data    (rom_data),
      .inst_valid  (inst_valid),
      .inst_opcode (inst_opcode),
      .inst_field  (inst_field),
      .inst_pc     (inst_pc),
      .halted      (halted),
      .state_dbg   (state_dbg)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Synchronous program ROM: word appears the cycle after the strobe.
   always @(posedge clk) begin
      if (rom_rd) rom_data <= rom[rom_addr];
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      n_vec++;
      if (obs !== exp_v) begin
         n_err++;
         $display("FAIL %s: got %0h, want %0h", tag, obs, exp_v);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [7:0] pc);
      sb_entry_t e;
      e.pc   = pc;
      e.word = rom[pc];
      exp_q.push_back(e);
   endtask

   task automatic check_reset_vals(input string tag);
      check({tag, "_rom_rd"},     {31'd0, rom_rd},     32'd0);
      check({tag, "_rom_addr"},   {24'd0, rom_addr},   32'd0);
      check({tag, "_inst_valid"}, {31'd0, inst_valid}, 32'd0);
      check({tag, "_halted"},     {31'd0, halted},     32'd0);
      check({tag, "_state"},      {29'd0, state_dbg},  32'd0);
      check({tag, "_opcode"},     {27'd0, inst_opcode}, 32'd0);
      check({tag, "_field"},      {21'd0, inst_field}, 32'd0);
      check({tag, "_inst_pc"},    {24'd0, inst_pc},    32'd0);
   endtask

   // Scoreboard: every accepted issue must match the next expected entry.
   always @(negedge clk) begin
      if (!reset && inst_valid && !stall) begin
         if (exp_q.size() == 0) begin
            check("sb_underflow", exp_q.size(), 32'd1);
         end else begin
            mon_e = exp_q.pop_front();
            $display("issue pc=%02h opcode=%02h field=%03h", inst_pc, inst_opcode, inst_field);
            check("issue_pc",     {24'd0, inst_pc},     {24'd0, mon_e.pc});
            check("issue_opcode", {27'd0, inst_opcode}, {27'd0, mon_e.word[15:11]});
            check("issue_field",  {21'd0, inst_field},  {21'd0, mon_e.word[10:0]});
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      for (int i = 0; i < 256; i++) rom[i] = {5'h02, 3'b000, i[7:0]};
      rom[0]    = 16'h0803;
      rom[1]    = 16'h1005;
      rom[2]    = 16'h1806;
      rom[8'h40] = 16'h2345;
      rom[8'hFF] = 16'h0ABC;
      reset = 1'b1; run = 1'b0; stall = 1'b0; branch_en = 1'b0; branch_addr = 8'h00;
      step(); step(); step();
      check_reset_vals("rst");

      // Basic sequential fetch with 3-cycle cadence.
      reset = 1'b0;
      step();
      push(8'h00); push(8'h01);
      run = 1'b1;
      step();
      check("n1_rom_rd",   {31'd0, rom_rd},   32'd1);
      check("n1_rom_addr", {24'd0, rom_addr}, 32'h00);
      step();
      check("n2_state",    {29'd0, state_dbg}, 32'd2);
      step();
      check("n3_valid",    {31'd0, inst_valid}, 32'd1);
      step();
      check("n4_rom_addr", {24'd0, rom_addr}, 32'h01);
      step(); step();
      check("n6_valid",    {31'd0, inst_valid}, 32'd1);

      // Stall holds the issued instruction for 4 cycles.
      stall = 1'b1;
      for (int k = 0; k < 4; k++) begin
         step();
         check("stl_valid",  {31'd0, inst_valid},  32'd1);
         check("stl_rom_rd", {31'd0, rom_rd},      32'd0);
         check("stl_opcode", {27'd0, inst_opcode}, 32'h02);
         check("stl_field",  {21'd0, inst_field},  32'h005);
         check("stl_pc",     {24'd0, inst_pc},     32'h01);
      end
      stall = 1'b0;
      step();
      check("rel_rom_rd",   {31'd0, rom_rd},   32'd1);
      check("rel_rom_addr", {24'd0, rom_addr}, 32'h02);
      push(8'h02);
      run = 1'b0;
      step(); step(); step();
      check("runoff_state", {29'd0, state_dbg}, 32'd0);
      check("runoff_rd",    {31'd0, rom_rd},    32'd0);

      // Branch during DECODE discards the in-flight word.
      run = 1'b1;
      step();
      check("br_fetch_addr", {24'd0, rom_addr}, 32'h03);
      step();
      branch_en = 1'b1; branch_addr = 8'h40;
      step();
      branch_en = 1'b0;
      check("br_rom_rd",   {31'd0, rom_rd},      32'd1);
      check("br_rom_addr", {24'd0, rom_addr},    32'h40);
      check("br_valid",    {31'd0, inst_valid},  32'd0);
      check("br_ir_pc",    {24'd0, inst_pc},     32'h02);
      check("br_ir_opc",   {27'd0, inst_opcode}, 32'h03);
      push(8'h40);
      step(); step(); step();
      // Branch during FETCH to the top of the address space.
      branch_en = 1'b1; branch_addr = 8'hFF;
      step();
      branch_en = 1'b0;
      check("brf_rom_addr", {24'd0, rom_addr}, 32'hFF);
      push(8'hFF);
      step(); step(); step();
      check("wrap_rom_addr", {24'd0, rom_addr}, 32'h00);
      step(); step();
      // Branch overrides a stall in ISSUE; the stalled word is never taken.
      stall = 1'b1; branch_en = 1'b1; branch_addr = 8'h10;
      step();
      check("brs_rom_addr", {24'd0, rom_addr},   32'h10);
      check("brs_valid",    {31'd0, inst_valid}, 32'd0);
      stall = 1'b0; branch_en = 1'b0; run = 1'b0;
      push(8'h10);
      step(); step(); step();
      check("brs_idle", {29'd0, state_dbg}, 32'd0);

      // HALT opcode at ROM[2].
      reset = 1'b1;
      rom[2] = 16'hF800;
      step(); step();
      reset = 1'b0;
      step();
      push(8'h00); push(8'h01);
      run = 1'b1;
      cyc = 0;
      while (!halted && cyc < 30) begin
         step();
         cyc++;
      end
      check("halt_cycles", cyc,                   32'd9);
      check("halt_state",  {29'd0, state_dbg},    32'd4);
      check("halt_ir_pc",  {24'd0, inst_pc},      32'h02);
      check("halt_ir_opc", {27'd0, inst_opcode},  32'h1F);
      branch_en = 1'b1; branch_addr = 8'h20;
      for (int k = 0; k < 3; k++) begin
         step();
         check("halt_hold",   {31'd0, halted},     32'd1);
         check("halt_rd",     {31'd0, rom_rd},     32'd0);
         check("halt_valid",  {31'd0, inst_valid}, 32'd0);
      end
      branch_en = 1'b0; run = 1'b0;
      rom[2] = 16'h1806;

      // Reset in FETCH with a read in flight.
      reset = 1'b1;
      step();
      reset = 1'b0; run = 1'b1;
      step();
      check("rf_rom_rd", {31'd0, rom_rd}, 32'd1);
      reset = 1'b1;
      step();
      check_reset_vals("rf");
      reset = 1'b0; run = 1'b0;
      step(); step();
      check("rf_idle",  {29'd0, state_dbg}, 32'd0);
      check("sb_drain", exp_q.size(),       32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule : tb_il_fetch_ctrl

// File: doc/il_fetch_ctrl.md
# il_fetch_ctrl

Instruction fetch sequencer for the instruction-list (IL) processor front end. Owns the program counter, drives synchronous program-ROM reads, captures the returned word into the instruction register and presents it split into opcode and operand field to decode. Handles downstream stalls, branch redirects from execute, and a HALT opcode.

## Interface
- PC_W, 8, program address width
- INST_W, 16, instruction word width
- OPC_W, 5, opcode width (upper bits of word); field width = INST_W-OPC_W
- HALT_OPC, 5'h1F, opcode that stops fetching

Ports:
- clk  in  1  system clock, all state on rising edge
- reset  in  1  synchronous, active-high
- run  in  1  level; permits fetching
- stall  in  1  decode cannot accept; holds issued instruction
- branch_en  in  1  one-cycle redirect request from execute
- branch_addr  in  PC_W  redirect target
- rom_rd  out  1  ROM read strobe
- rom_addr  out  PC_W  ROM address (= pc)
- rom_data  in  INST_W  ROM word, valid the cycle after rom_rd
- inst_valid  out  1  instruction presented to decode
- inst_opcode  out  OPC_W  IR[INST_W-1 : INST_W-OPC_W]
- inst_field  out  INST_W-OPC_W  IR[INST_W-OPC_W-1 : 0]
- inst_pc  out  PC_W  address of presented instruction
- halted  out  1  HALT decoded
- state_dbg  out  3  current FSM state encoding

## Operation
- States: IDLE, FETCH, DECODE, ISSUE, HALT.
- IDLE: all strobes low. run=1 -> FETCH.
- FETCH: rom_rd=1, rom_addr=pc. -> DECODE.
- DECODE: IR <= rom_data, inst_pc <= pc, pc <= pc+1 (mod 2^PC_W, 2^PC_W-1 wraps to 0). Opcode of rom_data == HALT_OPC -> HALT (IR still loaded, inst_valid never asserted for it); else -> ISSUE.
- ISSUE: inst_valid=1. stall=1 -> stay, IR/inst_pc frozen. stall=0: run=1 -> FETCH, run=0 -> IDLE.
- HALT: halted=1; exits only on reset.
- branch_en in FETCH, DECODE or ISSUE: pc <= branch_addr, next state FETCH; in-flight ROM word discarded (IR not loaded); overrides stall and HALT detection same cycle. branch_en ignored in IDLE and HALT.
- run deassert in FETCH/DECODE: current instruction completes through ISSUE, then IDLE.
- pc increment is PC_W-bit unsigned, no carry out.

## Timing
- Reset values: pc=0, state=IDLE, IR=0, inst_pc=0, rom_rd=0, rom_addr=0, inst_valid=0, halted=0, state_dbg=IDLE code.
- rom_rd and inst_valid are pure decodes of the registered state; rom_addr = registered pc.
- run sampled high in IDLE at cycle n: rom_rd at n+1, rom_data sampled at end of n+2, inst_valid at n+3.
- Unstalled throughput: one instruction per 3 cycles.
- Handshake: instruction transferred on any cycle with inst_valid=1 and stall=0; exactly once per issue.
- branch_en at cycle n: rom_rd with rom_addr=branch_addr at n+1; inst_valid low at n+1.
- reset during any state: next cycle IDLE, pending ROM read ignored, outputs at reset values.

## Structure
- Shared package il_pkg: state enum (IDLE=0, FETCH=1, DECODE=2, ISSUE=3, HALT=4), default widths, HALT_OPC constant.
- One sub-module natural: il_pc_counter (reset-to-0, load, increment with wrap).
- Everything else in one always block plus output decodes.

## Test plan
- Reset then run=1, ROM[0]=16'h0803, ROM[1]=16'h1005, stall=0 -> inst_valid at cycles 3 and 6; opcode 5'h01/field 11'h003 with inst_pc 0, then opcode 5'h02/field 11'h005 with inst_pc 1.
- stall=1 for 4 cycles while ISSUE -> inst_valid held, outputs unchanged, no rom_rd; release -> FETCH next cycle at pc+1.
- branch_en=1, branch_addr=8'h40 during DECODE -> IR not updated, next rom_addr=8'h40, next issued inst_pc=8'h40.
- pc=8'hFF fetch -> issued inst_pc=8'hFF, next rom_addr=8'h00.
- ROM[2] opcode=5'h1F -> halted=1 after DECODE, inst_valid never asserted for it, run/branch_en ignored until reset.
- reset asserted in FETCH with rom_rd=1 -> next cycle all outputs at reset values, state IDLE.
